sd_dat_wr_seq: RTL and testbench

Write-block sequencer for the DAT0 SD-card line, directly upstream of the DAT line byte transmitter. Drives the transmitter's load and select strobes in the fixed frame: start byte, BLK_LEN data bytes, CRC16 high byte, CRC16 low byte, end bit. Computes CRC16-CCITT over the data bytes, issues source read addresses and strobes, and optionally checks the card's CRC status token and busy phase.

---
 rtl/sd_dat_wr_seq.sv | 208 ++++++++++++++++++++
 tb/tb_sd_dat_wr_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dat_wr_seq.sv
// Write-block sequencer for SD DAT0: start byte, BLK_LEN data bytes, CRC16 hi/lo, end bit.
// Define SD_DATWR_STATUS_EN to add CRC status token capture and busy-phase checking.
module sd_dat_wr_seq #(
  parameter int unsigned BLK_LEN  = 512,
  parameter int unsigned NCRC_MAX = 16,
  parameter int unsigned BUSY_W   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  src,
  input  logic [7:0]  din,
  input  logic        dat_in,
  output logic        oe,
  output logic        load,
  output logic        sbit,
  output logic        null_byte,  // 'null' is a reserved word
  output logic        crc16h,
  output logic        crc16l,
  output logic        fifo,
  output logic        ram1,
  output logic        ram2,
  output logic [15:0] CRC16,
  output logic [9:0]  addr,
  output logic        fifo_rd,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status,
  output logic [1:0]  err
);

  localparam int unsigned ByteW = $clog2(BLK_LEN + 3);
  localparam int unsigned NcrcW = $clog2(NCRC_MAX + 1);
  localparam int unsigned CntW0 = (BUSY_W > 4) ? BUSY_W : 4;
  localparam int unsigned CntW  = (CntW0 > NcrcW) ? CntW0 : NcrcW;

`ifdef SD_DATWR_STATUS_EN
  typedef enum logic [2:0] {StIdle, StSend, StTail, StWaitTok, StToken, StBusyW, StFin} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSend, StTail, StFin} state_e;
`endif

  state_e           state;
  logic [2:0]       bit_cnt;
  logic [ByteW-1:0] byte_cnt;
  logic [CntW-1:0]  cnt;
  logic [1:0]       src_q;

  // CRC16-CCITT (x^16+x^12+x^5+1), MSB first
  function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] d);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

`ifndef SD_DATWR_STATUS_EN
  logic unused_dat_in;
  assign unused_dat_in = dat_in;
  assign status = 3'b111;
  assign err    = 2'd0;
`endif

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      oe        <= 1'b0;
      load      <= 1'b0;
      sbit      <= 1'b0;
      null_byte <= 1'b0;
      crc16h    <= 1'b0;
      crc16l    <= 1'b0;
      fifo      <= 1'b0;
      ram1      <= 1'b0;
      ram2      <= 1'b0;
      CRC16     <= 16'h0000;
      addr      <= 10'd0;
      fifo_rd   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= '0;
      cnt       <= '0;
      src_q     <= 2'd0;
`ifdef SD_DATWR_STATUS_EN
      status    <= 3'b111;
      err       <= 2'd0;
`endif
    end else begin
      load      <= 1'b0;
      sbit      <= 1'b0;
      null_byte <= 1'b0;
      crc16h    <= 1'b0;
      crc16l    <= 1'b0;
      fifo      <= 1'b0;
      ram1      <= 1'b0;
      ram2      <= 1'b0;
      done      <= 1'b0;
      // The FIFO is popped one cycle after its byte was loaded
      fifo_rd   <= fifo;
      case (state)
        StIdle: begin
          if (start) begin
            state    <= StSend;
            oe       <= 1'b1;
            load     <= 1'b1;
            sbit     <= 1'b1;
            busy     <= 1'b1;
            addr     <= 10'd0;
            CRC16    <= 16'h0000;
            byte_cnt <= '0;
            bit_cnt  <= 3'd0;
            src_q    <= src;
`ifdef SD_DATWR_STATUS_EN
            status   <= 3'b111;
            err      <= 2'd0;
`endif
          end
        end
        StSend: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_cnt <= byte_cnt + ByteW'(1);
            load     <= 1'b1;
            if (byte_cnt < ByteW'(BLK_LEN)) begin
              addr  <= addr + 10'd1;
              CRC16 <= crc_byte(CRC16, (src_q == 2'd3) ? 8'h00 : din);
              case (src_q)
                2'd0:    fifo      <= 1'b1;
                2'd1:    ram1      <= 1'b1;
                2'd2:    ram2      <= 1'b1;
                default: null_byte <= 1'b1;
              endcase
            end else if (byte_cnt == ByteW'(BLK_LEN)) begin
              crc16h <= 1'b1;
            end else begin
              crc16l <= 1'b1;
              cnt    <= '0;
              state  <= StTail;
            end
          end
        end
        StTail: begin
          // 8 CRC low bits plus the end bit
          if (cnt == CntW'(8)) begin
            oe    <= 1'b0;
            cnt   <= '0;
`ifdef SD_DATWR_STATUS_EN
            state <= StWaitTok;
`else
            state <= StFin;
`endif
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
`ifdef SD_DATWR_STATUS_EN
        StWaitTok: begin
          if (!dat_in) begin
            cnt   <= '0;
            state <= StToken;
          end else if (cnt == CntW'(NCRC_MAX - 1)) begin
            err   <= 2'd2;
            state <= StFin;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        StToken: begin
          if (cnt == CntW'(3)) begin
            cnt <= '0;
            if (status == 3'b010) begin
              state <= StBusyW;
            end else begin
              err   <= 2'd1;
              state <= StFin;
            end
          end else begin
            status <= {status[1:0], dat_in};
            cnt    <= cnt + CntW'(1);
          end
        end
        StBusyW: begin
          if (dat_in) begin
            err   <= 2'd0;
            state <= StFin;
          end else if (cnt == CntW'({BUSY_W{1'b1}})) begin
            err   <= 2'd3;
            state <= StFin;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
`endif
        StFin: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_wr_seq.sv
// Scoreboard bench for sd_dat_wr_seq: expected strobe order and end-of-block results are queued
// at stimulus time and checked by an independent monitor sampling on the posedge.
module tb_sd_dat_wr_seq;

  localparam int L    = 512;
  localparam int NCRC = 16;
  localparam int BW   = 8;

  logic        clk = 1'b0;
  logic        reset, start, dat_in;
  logic [1:0]  src;
  logic [7:0]  din;
  logic        oe, load, sbit, null_byte, crc16h, crc16l, fifo, ram1, ram2;
  logic [15:0] CRC16;
  logic [9:0]  addr;
  logic        fifo_rd, busy, done;
  logic [2:0]  status;
  logic [1:0]  err;

  always #5 clk = ~clk;

  sd_dat_wr_seq #(.BLK_LEN(L), .NCRC_MAX(NCRC), .BUSY_W(BW)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .din(din), .dat_in(dat_in),
    .oe(oe), .load(load), .sbit(sbit), .null_byte(null_byte), .crc16h(crc16h),
    .crc16l(crc16l), .fifo(fifo), .ram1(ram1), .ram2(ram2), .CRC16(CRC16), .addr(addr),
    .fifo_rd(fifo_rd), .busy(busy), .done(done), .status(status), .err(err)
  );

  typedef struct {
    logic [15:0] crc;
    logic [9:0]  addr;
    logic [2:0]  status;
    logic [1:0]  err;
    int          nfifo;
    int          oe_len;
  } exp_t;

  int   exp_strobe[$];  // 0 sbit, 1 fifo, 2 ram1, 3 ram2, 4 null, 5 crc16h, 6 crc16l
  exp_t exp_done[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;

  logic [7:0] ram1_mem[1024];
  logic [7:0] ram2_mem[1024];
  logic [7:0] fifo_mem[1024];
  logic [9:0] fifo_ptr = 10'd0;
  logic [1:0] mux_src = 2'd1;

  // Top-level byte mux; the null source presents garbage that must not reach the CRC
  always_comb begin
    case (mux_src)
      2'd0:    din = fifo_mem[fifo_ptr];
      2'd1:    din = ram1_mem[addr];
      2'd2:    din = ram2_mem[addr];
      default: din = ~ram1_mem[addr];
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // CRC as the remainder of M(x)*x^16 divided by the generator, by long division on a bit list
  function automatic logic [15:0] crc_model(input logic [7:0] data[$]);
    bit          m[$];
    logic [16:0] g;
    logic [15:0] r;
    int          nbits;
    g = 17'h11021;
    foreach (data[i]) for (int b = 7; b >= 0; b--) m.push_back(data[i][b]);
    nbits = m.size();
    repeat (16) m.push_back(1'b0);
    for (int i = 0; i < nbits; i++)
      if (m[i]) for (int j = 0; j <= 16; j++) m[i+j] = m[i+j] ^ g[16-j];
    for (int k = 0; k < 16; k++) r[15-k] = m[nbits+k];
    return r;
  endfunction

`ifdef SD_DATWR_STATUS_EN
  function automatic bit seq_at(input bit q[$], input int k);
    return (k < q.size()) ? q[k] : 1'b1;
  endfunction

  task automatic status_model(input bit q[$], output logic [2:0] st, output logic [1:0] er);
    int z, run;
    z  = -1;
    st = 3'b111;
    er = 2'd0;
    for (int k = 0; k < NCRC; k++) if (z < 0 && !seq_at(q, k)) z = k;
    if (z < 0) begin
      er = 2'd2;
      return;
    end
    st = {seq_at(q, z + 1), seq_at(q, z + 2), seq_at(q, z + 3)};
    if (st != 3'b010) begin
      er = 2'd1;
      return;
    end
    run = 0;
    while (run < (1 << BW) && !seq_at(q, z + 5 + run)) run++;
    er = (run >= (1 << BW)) ? 2'd3 : 2'd0;
  endtask
`endif

  // Line response after the end bit: idle ones, start 0, token, end 1, busy zeros, release
  task automatic make_seq(input int lead, input logic [2:0] tok, input int zeros, output bit q[$]);
    q.delete();
    repeat (lead) q.push_back(1'b1);
    q.push_back(1'b0);
    for (int i = 2; i >= 0; i--) q.push_back(tok[i]);
    q.push_back(1'b1);
    repeat (zeros) q.push_back(1'b0);
    q.push_back(1'b1);
  endtask

  task automatic monitor();
    int   code, nsel, since, nfifo, oe_len, ec;
    bit   prev_fifo;
    exp_t e;
    since = 0; nfifo = 0; oe_len = 0; prev_fifo = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        prev_fifo = 1'b0;
        since     = 0;
        continue;
      end
      since++;
      nsel = int'(sbit) + int'(null_byte) + int'(crc16h) + int'(crc16l) + int'(fifo)
           + int'(ram1) + int'(ram2);
      if (fifo_rd || prev_fifo) check("fifo_rd_timing", 32'(fifo_rd), 32'(prev_fifo));
      if (fifo_rd) begin
        nfifo++;
        fifo_ptr = fifo_ptr + 10'd1;
      end
      prev_fifo = fifo & load;
      if (oe) oe_len++;
      if (load) begin
        code = (nsel != 1) ? 7 : sbit ? 0 : fifo ? 1 : ram1 ? 2 : ram2 ? 3 :
               null_byte ? 4 : crc16h ? 5 : 6;
        if (exp_strobe.size() == 0) begin
          fail_now("unexpected_load");
        end else begin
          ec = exp_strobe.pop_front();
          check("strobe_select", 32'(code), 32'(ec));
          if (ec == 0) begin
            nfifo  = 0;
            oe_len = 1;
          end else begin
            check("load_spacing", 32'(since), 32'd8);
          end
          check("busy_oe_at_load", {30'd0, busy, oe}, 32'd3);
        end
        since = 0;
      end else if (nsel != 0) begin
        fail_now("select_without_load");
      end
      if (done) begin
        n_done++;
        if (exp_done.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = exp_done.pop_front();
          check("crc16", 32'(CRC16), 32'(e.crc));
          check("addr_end", 32'(addr), 32'(e.addr));
          check("status", 32'(status), 32'(e.status));
          check("err", 32'(err), 32'(e.err));
          check("fifo_rd_count", 32'(nfifo), 32'(e.nfifo));
          check("oe_cycles", 32'(oe_len), 32'(e.oe_len));
          check("busy_oe_at_done", {30'd0, busy, oe}, 32'd0);
        end
      end
    end
  endtask

  task automatic run_block(input logic [1:0] s, input bit seq[$], input int second_at,
                           input int abort_at);
    logic [7:0] data[$];
    logic [9:0] p;
    exp_t       e;
    int         n, d0;
    for (int i = 0; i < L; i++) begin
      p = fifo_ptr + 10'(i);
      case (s)
        2'd0:    data.push_back(fifo_mem[p]);
        2'd1:    data.push_back(ram1_mem[i]);
        2'd2:    data.push_back(ram2_mem[i]);
        default: data.push_back(8'h00);
      endcase
    end
    e.crc    = crc_model(data);
    e.addr   = 10'(L);
    e.nfifo  = (s == 2'd0) ? L : 0;
    e.oe_len = 8 * (L + 3) + 1;
`ifdef SD_DATWR_STATUS_EN
    status_model(seq, e.status, e.err);
`else
    e.status = 3'b111;
    e.err    = 2'd0;
`endif
    exp_strobe.push_back(0);
    repeat (L) exp_strobe.push_back(int'(s) + 1);
    exp_strobe.push_back(5);
    exp_strobe.push_back(6);
    exp_done.push_back(e);
    mux_src = s;
    d0 = n_done;

    @(posedge clk);
    start = 1'b1;
    src   = s;
    @(posedge clk);
    start = 1'b0;
    src   = 2'($urandom);

    if (abort_at > 0) begin
      n = 0;
      while (addr < 10'(abort_at) && n < 3000) begin
        @(posedge clk);
        n++;
      end
      if (n >= 3000) fail_now("abort_point_timeout");
      #2 reset = 1'b1;
      #1;
      check("abort_oe_busy", {30'd0, oe, busy}, 32'd0);
      check("abort_addr_crc", {6'd0, addr, CRC16}, 32'd0);
      check("abort_status", 32'(status), 32'h7);
      exp_strobe.delete();
      exp_done.delete();
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      repeat (4) @(posedge clk);
      check("abort_no_done", 32'(n_done - d0), 32'd0);
      return;
    end

    if (second_at > 0) begin
      repeat (second_at) @(posedge clk);
      start = 1'b1;
      src   = s ^ 2'd1;
      repeat (3) @(posedge clk);
      start = 1'b0;
    end

    n = 0;
    while (oe && n < 5000) begin
      dat_in = 1'($urandom);
      @(posedge clk);
      n++;
    end
    if (n >= 5000) fail_now("oe_fall_timeout");
    foreach (seq[k]) begin
      dat_in = seq[k];
      @(posedge clk);
    end
    dat_in = 1'b1;
    n = 0;
    while (n_done == d0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check("done_pulses", 32'(n_done - d0), 32'd1);
  endtask

  task automatic stimulus();
    bit q_good[$], q_bad[$], q_none[$], q_stuck[$];
    reset  = 1'b1;
    start  = 1'b0;
    src    = 2'd0;
    dat_in = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      ram1_mem[i] = 8'(i);
      ram2_mem[i] = 8'($urandom);
      fifo_mem[i] = 8'($urandom);
    end
    #12;
    check("reset_strobes", {20'd0, load, sbit, null_byte, crc16h, crc16l, fifo, ram1, ram2,
                            fifo_rd, busy, done, oe}, 32'd0);
    check("reset_crc_addr", {6'd0, addr, CRC16}, 32'd0);
    check("reset_status_err", {27'd0, status, err}, 32'h1c);
    @(posedge clk);
    #2 reset = 1'b0;

    make_seq(2, 3'b010, 100, q_good);
    make_seq(0, 3'b101, 10, q_bad);
    make_seq(40, 3'b010, 0, q_none);
    make_seq(1, 3'b010, 300, q_stuck);

    run_block(2'd1, q_good, 0, 0);
    run_block(2'd3, q_bad, 0, 0);
    run_block(2'd0, q_good, 120, 0);
    run_block(2'd2, q_none, 0, 0);
    for (int i = 0; i < 1024; i++) ram1_mem[i] = 8'($urandom);
    run_block(2'd1, q_good, 0, 200);
    run_block(2'd1, q_good, 0, 0);
    run_block(2'($urandom), q_stuck, 0, 0);

    check("strobe_queue_empty", 32'(exp_strobe.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_none
  end

endmodule
